// File: rtl/ras_ckpt_pkg.sv
// ras_ckpt_pkg: shared RAS op encoding and default geometry for fetch, BTB and BOB.
package ras_ckpt_pkg;
  localparam int RAS_DATA_W = 64;
  localparam int RAS_DEPTH  = 16;
  typedef enum logic [1:0] {
    RAS_NOP     = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_POPPUSH = 2'b11
  } ras_op_e;
endpackage

// File: rtl/ras_ckpt_if.sv
// ras_ckpt_if: op request, flush/checkpoint restore and prediction outputs of the RAS.
interface ras_ckpt_if
  import ras_ckpt_pkg::*;
#(
  parameter int DATA_W = RAS_DATA_W,
  parameter int DEPTH  = RAS_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic              op_vld_i;
  logic [1:0]        op_i;
  logic              cancel_i;
  logic [DATA_W-1:0] push_data_i;
  logic              flush_i;
  logic [PTR_W-1:0]  flush_ptr_i;
  logic [CNT_W-1:0]  flush_cnt_i;
  logic [DATA_W-1:0] flush_top_i;
  logic [DATA_W-1:0] top_data_o;
  logic              top_vld_o;
  logic [PTR_W-1:0]  ckpt_ptr_o;
  logic [CNT_W-1:0]  ckpt_cnt_o;
  logic [DATA_W-1:0] ckpt_top_o;
  logic              ovf_o;
  logic              unf_o;
  modport master (
    output op_vld_i, op_i, cancel_i, push_data_i, flush_i, flush_ptr_i, flush_cnt_i, flush_top_i,
    input  top_data_o, top_vld_o, ckpt_ptr_o, ckpt_cnt_o, ckpt_top_o, ovf_o, unf_o
  );
  modport slave (
    input  op_vld_i, op_i, cancel_i, push_data_i, flush_i, flush_ptr_i, flush_cnt_i, flush_top_i,
    output top_data_o, top_vld_o, ckpt_ptr_o, ckpt_cnt_o, ckpt_top_o, ovf_o, unf_o
  );
endinterface

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return address stack with post-op checkpoint export and flush repair.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int DATA_W = RAS_DATA_W,
  parameter int DEPTH  = RAS_DEPTH
) (
  input logic        clock,
  input logic        reset_n,
  ras_ckpt_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  ras_op_e           eff;
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              full, empty, push, pop, repl, we;
  logic [DATA_W-1:0] wdata;
  // A write always lands at the next top, so the single write port is addressed by tos_d.
  always_comb begin
    eff   = (bus.op_vld_i && !bus.cancel_i && !bus.flush_i) ? ras_op_e'(bus.op_i) : RAS_NOP;
    full  = cnt_q == CNT_W'(DEPTH);
    empty = cnt_q == '0;
    push  = eff == RAS_PUSH || (eff == RAS_POPPUSH && empty);
    pop   = eff == RAS_POP && !empty;
    repl  = eff == RAS_POPPUSH && !empty;
    tos_d = bus.flush_i ? bus.flush_ptr_i : push ? tos_q + PTR_W'(1) : pop ? tos_q - PTR_W'(1) : tos_q;
    cnt_d = bus.flush_i ? bus.flush_cnt_i : (push && !full) ? cnt_q + CNT_W'(1) : pop ? cnt_q - CNT_W'(1) : cnt_q;
    we    = bus.flush_i || push || repl;
    wdata = bus.flush_i ? bus.flush_top_i : bus.push_data_i;
  end
  assign bus.top_data_o = mem_q[tos_q];
  assign bus.top_vld_o  = !empty;
  assign bus.ckpt_ptr_o = tos_d;
  assign bus.ckpt_cnt_o = cnt_d;
  assign bus.ckpt_top_o = we ? wdata : mem_q[tos_d];
  assign bus.ovf_o      = push && full;
  assign bus.unf_o      = eff == RAS_POP && empty;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tos_q <= PTR_W'(DEPTH - 1);
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (we) mem_q[tos_d] <= wdata;
    end
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: random and directed stimulus against a stack-semantics model of ras_ckpt.
module tb_ras_ckpt;
  localparam int D = 16;
  logic clock = 0;
  logic reset_n = 0;
  logic chk_en = 0;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  ras_ckpt_if #(.DATA_W(64), .DEPTH(D)) bus ();
  ras_ckpt #(.DATA_W(64), .DEPTH(D)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  typedef struct {
    int          tos;
    int          cnt;
    logic [63:0] top;
    logic        ov;
    logic        un;
    logic        we;
    int          wa;
    logic [63:0] wd;
  } pred_t;
  int          m_tos;
  int          m_cnt;
  logic [63:0] m_mem [D];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic pred_t predict();
    pred_t p;
    logic [1:0] op;
    p.tos = m_tos; p.cnt = m_cnt; p.ov = 0; p.un = 0; p.we = 0; p.wa = 0; p.wd = 0;
    op = (bus.op_vld_i && !bus.cancel_i) ? bus.op_i : 2'd0;
    if (bus.flush_i) begin
      p.tos = int'(bus.flush_ptr_i); p.cnt = int'(bus.flush_cnt_i);
      p.we = 1; p.wa = p.tos; p.wd = bus.flush_top_i;
    end else if (op == 2'd1 || (op == 2'd3 && m_cnt == 0)) begin
      p.tos = (m_tos + 1) % D;
      p.ov  = m_cnt == D;
      p.cnt = p.ov ? D : m_cnt + 1;
      p.we = 1; p.wa = p.tos; p.wd = bus.push_data_i;
    end else if (op == 2'd2) begin
      if (m_cnt == 0) p.un = 1;
      else begin p.tos = (m_tos + D - 1) % D; p.cnt = m_cnt - 1; end
    end else if (op == 2'd3) begin
      p.we = 1; p.wa = m_tos; p.wd = bus.push_data_i;
    end
    p.top = (p.we && p.wa == p.tos) ? p.wd : m_mem[p.tos];
    return p;
  endfunction
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_tos = D - 1; m_cnt = 0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else begin
      pred_t p;
      p = predict();
      if (p.we) m_mem[p.wa] = p.wd;
      m_tos = p.tos; m_cnt = p.cnt;
    end
  always @(negedge clock) begin
    #2;
    if (chk_en && reset_n) begin
      pred_t p;
      p = predict();
      chk("top_data", bus.top_data_o, m_mem[m_tos]);
      chk("top_vld", 64'(bus.top_vld_o), 64'(m_cnt > 0));
      chk("ckpt_ptr", 64'(bus.ckpt_ptr_o), 64'(p.tos));
      chk("ckpt_cnt", 64'(bus.ckpt_cnt_o), 64'(p.cnt));
      chk("ckpt_top", bus.ckpt_top_o, p.top);
      chk("ovf", 64'(bus.ovf_o), 64'(p.ov));
      chk("unf", 64'(bus.unf_o), 64'(p.un));
    end
  end
  task automatic drive(input logic v, input logic [1:0] op, input logic c, input logic [63:0] d,
                       input logic f, input logic [3:0] fp, input logic [4:0] fc, input logic [63:0] ft);
    @(negedge clock);
    bus.op_vld_i = v; bus.op_i = op; bus.cancel_i = c; bus.push_data_i = d;
    bus.flush_i = f; bus.flush_ptr_i = fp; bus.flush_cnt_i = fc; bus.flush_top_i = ft;
    #3;
  endtask
  task automatic idle();                   drive(0, 2'd0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input logic [63:0] d); drive(1, 2'd1, 0, d, 0, 0, 0, 0); endtask
  task automatic pop();                    drive(1, 2'd2, 0, 0, 0, 0, 0, 0); endtask
  task automatic poppush(input logic [63:0] d); drive(1, 2'd3, 0, d, 0, 0, 0, 0); endtask
  task automatic do_reset();
    chk_en = 0;
    reset_n = 0;
    bus.op_vld_i = 0; bus.op_i = 0; bus.cancel_i = 0; bus.push_data_i = 0;
    bus.flush_i = 0; bus.flush_ptr_i = 0; bus.flush_cnt_i = 0; bus.flush_top_i = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    chk_en = 1;
  endtask
  localparam logic [63:0] A = 64'hAAAA_0001, B = 64'hBBBB_0002, C = 64'hCCCC_0003;
  initial begin
    do_reset();
    idle();
    chk("rst_top_vld", 64'(bus.top_vld_o), 0);
    chk("rst_ckpt_cnt", 64'(bus.ckpt_cnt_o), 0);
    chk("rst_top_data", bus.top_data_o, 0);
    push(A); push(B); push(C); idle();
    chk("abc_top", bus.top_data_o, C);
    chk("abc_cnt", 64'(bus.ckpt_cnt_o), 3);
    pop(); idle(); chk("pop1_top", bus.top_data_o, B);
    pop(); idle(); chk("pop2_top", bus.top_data_o, A);
    pop(); idle(); chk("pop3_vld", 64'(bus.top_vld_o), 0);
    pop(); chk("extra_pop_unf", 64'(bus.unf_o), 1);
    idle(); chk("extra_pop_cnt", 64'(bus.ckpt_cnt_o), 0);
    for (int i = 1; i <= 17; i++) begin
      push(64'(i));
      if (i == 17) chk("ovf_17th", 64'(bus.ovf_o), 1);
      else if (i == 16) chk("no_ovf_16th", 64'(bus.ovf_o), 0);
    end
    idle(); chk("ovf_cnt", 64'(bus.ckpt_cnt_o), 16);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("ovf_pop_top", bus.top_data_o, 64'(17 - i));
    end
    pop(); chk("ovf_17th_pop_unf", 64'(bus.unf_o), 1);
    do_reset();
    push(A); push(B);
    chk("ckpt_ptr", 64'(bus.ckpt_ptr_o), 1);
    chk("ckpt_cnt", 64'(bus.ckpt_cnt_o), 2);
    chk("ckpt_top", bus.ckpt_top_o, B);
    poppush(64'hDEAD); push(64'hBEEF);
    drive(0, 2'd0, 0, 0, 1, 4'd1, 5'd2, B);
    idle();
    chk("repair_top", bus.top_data_o, B);
    chk("repair_cnt", 64'(bus.ckpt_cnt_o), 2);
    pop(); idle(); chk("repair_pop_top", bus.top_data_o, A);
    push(64'h5555);
    drive(1, 2'd1, 0, 64'h2222_2222, 1, 4'd1, 5'd2, B);
    chk("flush_op_ckpt_top", bus.ckpt_top_o, B);
    chk("flush_op_ovf", 64'(bus.ovf_o), 0);
    idle();
    chk("flush_op_top", bus.top_data_o, B);
    chk("flush_op_cnt", 64'(bus.ckpt_cnt_o), 2);
    drive(1, 2'd1, 1, 64'h7777, 0, 0, 0, 0);
    chk("cancel_ptr", 64'(bus.ckpt_ptr_o), 1);
    chk("cancel_cnt", 64'(bus.ckpt_cnt_o), 2);
    chk("cancel_top", bus.ckpt_top_o, B);
    do_reset();
    poppush(64'h9999);
    chk("pp_empty_unf", 64'(bus.unf_o), 0);
    chk("pp_empty_cnt", 64'(bus.ckpt_cnt_o), 1);
    idle(); chk("pp_empty_top", bus.top_data_o, 64'h9999);
    push(64'h4444); push(64'h6666);
    bus.op_vld_i = 0;
    reset_n = 0;
    chk_en = 0;
    #1;
    chk("async_rst_vld", 64'(bus.top_vld_o), 0);
    chk("async_rst_top", bus.top_data_o, 0);
    chk("async_rst_cnt", 64'(bus.ckpt_cnt_o), 0);
    @(negedge clock);
    reset_n = 1;
    chk_en = 1;
    for (int ph = 0; ph < 6; ph++)
      for (int n = 0; n < 500; n++) begin
        int r;
        logic [1:0] op;
        r = int'($urandom_range(0, 99));
        op = (int'($urandom_range(0, 99)) < (ph[0] ? 30 : 70)) ? 2'd1 : 2'($urandom_range(0, 3));
        drive(r < 90, op, $urandom_range(0, 9) == 0, {$urandom, $urandom}, r >= 96,
              4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)), {$urandom, $urandom});
      end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
